// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 16-bit five-stage core: EX/MA destination scoreboard, RAW forwarding selects,
// load-use stall, taken-branch flush and RAM-busy freeze. Define PIPE_HAZARD_FWD_EN to enable forwarding.
module pipe_hazard_ctrl #(
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic        br_taken,
    input  logic        ram_busy,
    output logic        stall_if_id,
    output logic        bubble_ex,
    output logic        flush_if_id,
    output logic        freeze,
    output logic [1:0]  fwd_op1_sel,
    output logic [1:0]  fwd_op2_sel,
    output logic        fwd_ram_sel
);

    typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, FREEZE} state_t;

    state_t      state_q;
    state_t      resume_q;
    state_t      cur;

    logic        id_real;
    logic [3:0]  opc;
    logic [2:0]  f_rs, f_rt, f_rd;
    logic [2:0]  src1, src2, dst;
    logic        is_ld, is_sw;

    // Scoreboard; MA needs no load flag since MA/WB already carries load data.
    logic        ex_v, ex_ld, ma_v;
    logic [2:0]  ex_reg, ma_reg;

    logic        ex_hit1, ex_hit2, ma_hit1, ma_hit2;
    logic        load_use, raw_any, hazard, owed, advance;
    logic [1:0]  op1_next, op2_next;
    logic        ram_next, ram_pend;

    assign id_real = id_valid && (id_instr != NOP_WORD);
    assign opc     = id_instr[15:12];
    assign f_rs    = id_instr[11:9];
    assign f_rt    = id_instr[8:6];
    assign f_rd    = id_instr[5:3];

    // Register 0 is encoded as "no register", so r0 can never match.
    always_comb begin
        src1  = '0;
        src2  = '0;
        dst   = '0;
        is_ld = 1'b0;
        is_sw = 1'b0;
        case (opc)
            4'd0: begin
                src1 = f_rs;
                src2 = f_rt;
                dst  = f_rd;
            end
            4'd1, 4'd3: begin
                src1 = f_rt;
                dst  = f_rs;
            end
            4'd4: begin
                src1  = f_rs;
                dst   = f_rt;
                is_ld = 1'b1;
            end
            4'd5: begin
                src1  = f_rs;
                src2  = f_rt;
                is_sw = 1'b1;
            end
            4'd6: begin
                src1 = f_rs;
                src2 = f_rt;
            end
            default: ;
        endcase
        if (!id_real) begin
            src1  = '0;
            src2  = '0;
            dst   = '0;
            is_ld = 1'b0;
            is_sw = 1'b0;
        end
    end

    assign ex_hit1 = (src1 != 3'd0) && ex_v && (ex_reg == src1);
    assign ex_hit2 = (src2 != 3'd0) && ex_v && (ex_reg == src2);
    assign ma_hit1 = (src1 != 3'd0) && ma_v && (ma_reg == src1);
    assign ma_hit2 = (src2 != 3'd0) && ma_v && (ma_reg == src2);

    assign load_use = ex_ld && (ex_hit1 || (ex_hit2 && !is_sw));
    assign raw_any  = ex_hit1 || ex_hit2 || ma_hit1 || ma_hit2;

`ifdef PIPE_HAZARD_FWD_EN
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic ma_hit, input logic ex_is_ld);
        if (ex_hit)
            return ex_is_ld ? 2'b00 : 2'b01;
        if (ma_hit)
            return 2'b10;
        return 2'b00;
    endfunction

    assign hazard   = load_use;
    assign op1_next = advance ? fwd_pick(ex_hit1, ma_hit1, ex_ld) : 2'b00;
    assign op2_next = advance ? fwd_pick(ex_hit2, ma_hit2, ex_ld) : 2'b00;
    assign ram_next = advance && is_sw && ex_hit2 && ex_ld;
`else
    // load_use is a subset of raw_any; without forwarding every RAW match stalls.
    assign hazard   = load_use || raw_any;
    assign op1_next = 2'b00;
    assign op2_next = 2'b00;
    assign ram_next = 1'b0;
`endif

    // A branch that arrived while frozen is owed and executes on the first unfrozen cycle.
    assign owed = (state_q == FREEZE) && (resume_q == FLUSH);

    always_comb begin
        cur = RUN;
        if (!rst)
            cur = RUN;
        else if (ram_busy)
            cur = FREEZE;
        else if (br_taken || owed)
            cur = FLUSH;
        else if (hazard)
            cur = LDSTALL;
    end

    assign freeze      = (cur == FREEZE);
    assign flush_if_id = (cur == FLUSH);
    assign stall_if_id = (cur == LDSTALL);
    assign bubble_ex   = (cur == FLUSH) || (cur == LDSTALL);
    assign advance     = (cur == RUN) && id_real;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            resume_q    <= RUN;
            ex_v        <= 1'b0;
            ex_reg      <= '0;
            ex_ld       <= 1'b0;
            ma_v        <= 1'b0;
            ma_reg      <= '0;
            fwd_op1_sel <= '0;
            fwd_op2_sel <= '0;
            ram_pend    <= 1'b0;
            fwd_ram_sel <= 1'b0;
        end else if (cur == FREEZE) begin
            state_q <= FREEZE;
            if (br_taken || owed)
                resume_q <= FLUSH;
            else if (state_q != FREEZE)
                resume_q <= state_q;
        end else begin
            state_q     <= cur;
            resume_q    <= RUN;
            ma_v        <= ex_v;
            ma_reg      <= ex_reg;
            ex_v        <= advance && (dst != 3'd0);
            ex_reg      <= advance ? dst : 3'd0;
            ex_ld       <= advance && is_ld;
            fwd_op1_sel <= op1_next;
            fwd_op2_sel <= op2_next;
            ram_pend    <= ram_next;
            fwd_ram_sel <= ram_pend;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed program scenarios plus randomized traffic
// against a queue-based pipeline model. Honours PIPE_HAZARD_FWD_EN the same way as the design.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] id_instr = 16'h0000;
    logic        id_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic        ram_busy = 1'b0;
    logic        stall_if_id, bubble_ex, flush_if_id, freeze;
    logic [1:0]  fwd_op1_sel, fwd_op2_sel;
    logic        fwd_ram_sel;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NOP_WORD(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .br_taken    (br_taken),
        .ram_busy    (ram_busy),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .flush_if_id (flush_if_id),
        .freeze      (freeze),
        .fwd_op1_sel (fwd_op1_sel),
        .fwd_op2_sel (fwd_op2_sel),
        .fwd_ram_sel (fwd_ram_sel)
    );

`ifdef PIPE_HAZARD_FWD_EN
    localparam int         EX_STALLS = 0, MA_STALLS = 0, LD_STALLS = 1;
    localparam logic [1:0] EX_SEL = 2'b01, MA_SEL = 2'b10, LD_SEL = 2'b10;
`else
    localparam int         EX_STALLS = 2, MA_STALLS = 1, LD_STALLS = 2;
    localparam logic [1:0] EX_SEL = 2'b00, MA_SEL = 2'b00, LD_SEL = 2'b00;
`endif

    int checks = 0;
    int failures = 0;

    // Model: the two most recently issued instructions, [0] in EX and [1] in MA.
    typedef struct packed { bit v; bit [2:0] r; bit ld; } slot_t;
    typedef struct packed { bit [2:0] s1; bit [2:0] s2; bit [2:0] d; bit ld; bit sw; } dec_t;
    slot_t pipe_q[$];
    bit       owed = 1'b0;
    bit [1:0] m_op1 = 2'b00, m_op2 = 2'b00;
    bit       m_ram = 1'b0, m_ram_pend = 1'b0;

    logic [15:0] prog_q[$];
    logic [8:0]  obs_q[$], exp_q[$];
    int          last_issue;

    function automatic dec_t decode(input logic [15:0] w, input logic vld);
        dec_t r;
        logic [2:0] rs, rt, rd;
        r  = '0;
        rs = w[11:9];
        rt = w[8:6];
        rd = w[5:3];
        if (!vld || w == 16'h0000)
            return r;
        case (w[15:12])
            4'd0:       begin r.s1 = rs; r.s2 = rt; r.d = rd; end
            4'd1, 4'd3: begin r.s1 = rt; r.d = rs; end
            4'd4:       begin r.s1 = rs; r.d = rt; r.ld = 1'b1; end
            4'd5:       begin r.s1 = rs; r.s2 = rt; r.sw = 1'b1; end
            4'd6:       begin r.s1 = rs; r.s2 = rt; end
            default:    ;
        endcase
        return r;
    endfunction

    // 0 none, 1 EX producer (ALU), 2 MA producer, 3 EX producer is a load
    function automatic int who(input bit [2:0] s);
        if (s == 3'd0) return 0;
        if (pipe_q[0].v && pipe_q[0].r == s) return pipe_q[0].ld ? 3 : 1;
        if (pipe_q[1].v && pipe_q[1].r == s) return 2;
        return 0;
    endfunction

    function automatic bit [1:0] pick(input int o);
        return (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00;
    endfunction

    // 0 issue, 1 stall, 2 flush, 3 freeze
    function automatic int m_action();
        dec_t dc;
        int   o1, o2;
        bit   haz;
        if (!rst) return 0;
        if (ram_busy) return 3;
        if (br_taken || owed) return 2;
        dc = decode(id_instr, id_valid);
        o1 = who(dc.s1);
        o2 = who(dc.s2);
`ifdef PIPE_HAZARD_FWD_EN
        haz = (o1 == 3) || (o2 == 3 && !dc.sw);
`else
        haz = (o1 != 0) || (o2 != 0);
`endif
        return haz ? 1 : 0;
    endfunction

    function automatic logic [8:0] exp_vec();
        int a;
        a = m_action();
        return {a == 1, a == 1 || a == 2, a == 2, a == 3, m_op1, m_op2, m_ram};
    endfunction

    task automatic model_commit();
        dec_t  dc;
        int    o1, o2, act;
        bit    adv;
        slot_t s;
        if (!rst) begin
            pipe_q = {};
            pipe_q.push_back('0);
            pipe_q.push_back('0);
            owed = 1'b0; m_op1 = 2'b00; m_op2 = 2'b00; m_ram = 1'b0; m_ram_pend = 1'b0;
            return;
        end
        act = m_action();
        if (act == 3) begin
            owed = owed || br_taken;
            return;
        end
        owed = 1'b0;
        dc  = decode(id_instr, id_valid);
        o1  = who(dc.s1);
        o2  = who(dc.s2);
        adv = (act == 0) && id_valid;
`ifdef PIPE_HAZARD_FWD_EN
        m_ram      = m_ram_pend;
        m_ram_pend = adv && dc.sw && (o2 == 3);
        m_op1      = adv ? pick(o1) : 2'b00;
        m_op2      = adv ? pick(o2) : 2'b00;
`endif
        s = '0;
        if (adv && dc.d != 3'd0) begin
            s.v = 1'b1; s.r = dc.d; s.ld = dc.ld;
        end
        void'(pipe_q.pop_back());
        pipe_q.push_front(s);
    endtask

    task automatic tick(input logic vld, input logic [15:0] w, input logic br, input logic busy,
                        output logic [8:0] o, output logic [8:0] e);
        id_valid = vld; id_instr = w; br_taken = br; ram_busy = busy;
        @(negedge clk);
        o = {stall_if_id, bubble_ex, flush_if_id, freeze, fwd_op1_sel, fwd_op2_sel, fwd_ram_sel};
        e = exp_vec();
    endtask

    task automatic commit();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic run_prog(input int ncyc);
        int pc;
        logic [8:0] o, e;
        logic vld;
        logic [15:0] w;
        pc = 0; obs_q = {}; exp_q = {}; last_issue = -1;
        for (int c = 0; c < ncyc; c++) begin
            vld = (pc < prog_q.size());
            w   = vld ? prog_q[pc] : 16'h0000;
            tick(vld, w, 1'b0, 1'b0, o, e);
            obs_q.push_back(o);
            exp_q.push_back(e);
            if (vld && !e[8]) begin
                pc++;
                if (pc == prog_q.size()) last_issue = c;
            end
            commit();
        end
    endtask

    task automatic test_reset();
        logic [8:0] o, e;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), o, e);
            if (c > 0) begin
                checks++;
                if (o !== 9'd0) begin failures++; $display("FAIL reset cycle %0d: got %b, want 000000000", c, o); end
            end
            commit();
        end
        rst = 1'b1;
    endtask

    task automatic test_fwd_ex();
        int stalls;
        stalls = 0;
        prog_q = {16'h04C8, 16'h0360};
        run_prog(8);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL fwd_ex cycle %0d: got %b, want %b", i, obs_q[i], exp_q[i]); end
            if (obs_q[i][8]) stalls++;
        end
        checks++;
        if (stalls != EX_STALLS) begin failures++; $display("FAIL fwd_ex_stalls: got %0d, want %0d", stalls, EX_STALLS); end
        checks++;
        if (last_issue < 0 || obs_q[last_issue + 1][4:3] !== EX_SEL) begin
            failures++; $display("FAIL fwd_ex_op1: issue cycle %0d, want op1 %b", last_issue, EX_SEL);
        end
    endtask

    task automatic test_fwd_ma();
        int stalls;
        stalls = 0;
        prog_q = {16'h04C8, 16'h0B60, 16'h0360};
        run_prog(8);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL fwd_ma cycle %0d: got %b, want %b", i, obs_q[i], exp_q[i]); end
            if (obs_q[i][8]) stalls++;
        end
        checks++;
        if (stalls != MA_STALLS) begin failures++; $display("FAIL fwd_ma_stalls: got %0d, want %0d", stalls, MA_STALLS); end
        checks++;
        if (last_issue < 0 || obs_q[last_issue + 1][4:3] !== MA_SEL) begin
            failures++; $display("FAIL fwd_ma_op1: issue cycle %0d, want op1 %b", last_issue, MA_SEL);
        end
    endtask

    task automatic test_load_use();
        int stalls;
        stalls = 0;
        prog_q = {16'h4440, 16'h0360};
        run_prog(8);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL load_use cycle %0d: got %b, want %b", i, obs_q[i], exp_q[i]); end
            if (obs_q[i][8] && obs_q[i][7]) stalls++;
        end
        checks++;
        if (stalls != LD_STALLS) begin failures++; $display("FAIL load_use_stalls: got %0d, want %0d", stalls, LD_STALLS); end
        checks++;
        if (last_issue < 0 || obs_q[last_issue + 1][4:3] !== LD_SEL) begin
            failures++; $display("FAIL load_use_op1: issue cycle %0d, want op1 %b", last_issue, LD_SEL);
        end
    endtask

    task automatic test_r0();
        int stalls;
        stalls = 0;
        prog_q = {16'h04C0, 16'h0010};
        run_prog(6);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL r0 cycle %0d: got %b, want %b", i, obs_q[i], exp_q[i]); end
            if (obs_q[i][8]) stalls++;
        end
        checks++;
        if (stalls != 0) begin failures++; $display("FAIL r0_stalls: got %0d, want 0", stalls); end
        checks++;
        if (last_issue < 0 || obs_q[last_issue + 1][4:1] !== 4'b0000) begin
            failures++; $display("FAIL r0_sel: issue cycle %0d, want sels 0000", last_issue);
        end
    endtask

    task automatic test_branch_freeze();
        logic [8:0] o, e;
        bit br_t[6]     = '{1, 0, 0, 0, 1, 0};
        bit busy_t[6]   = '{1, 1, 0, 0, 0, 0};
        bit flush_t[6]  = '{0, 0, 1, 0, 1, 0};
        bit freeze_t[6] = '{1, 1, 0, 0, 0, 0};
        for (int c = 0; c < 6; c++) begin
            tick(1'b1, 16'h0B60, br_t[c], busy_t[c], o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL branch cycle %0d: got %b, want %b", c, o, e); end
            checks++;
            if ({o[6], o[5]} !== {flush_t[c], freeze_t[c]}) begin
                failures++; $display("FAIL branch_flush_freeze cycle %0d: got %b%b, want %b%b", c, o[6], o[5], flush_t[c], freeze_t[c]);
            end
            commit();
        end
    endtask

    task automatic test_rst_mid_ldstall();
        logic [8:0] o, e;
        tick(1'b1, 16'h4440, 1'b0, 1'b0, o, e);
        commit();
        tick(1'b1, 16'h0360, 1'b0, 1'b0, o, e);
        checks++;
        if (o[8] !== 1'b1 || o !== e) begin failures++; $display("FAIL ldstall_before_rst: got %b, want %b", o, e); end
        commit();
        rst = 1'b0;
        tick(1'b1, 16'h0360, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL rst_cycle: got %b, want %b", o, e); end
        commit();
        rst = 1'b1;
        tick(1'b1, 16'h0360, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== 9'd0) begin failures++; $display("FAIL after_rst: got %b, want 000000000", o); end
        commit();
    endtask

    task automatic test_random();
        logic [8:0] o, e;
        logic [3:0] ops[8] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd2, 4'd4};
        logic [15:0] w;
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            w = {ops[$urandom_range(0, 7)], 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                 3'($urandom_range(0, 3)), 3'($urandom)};
            rst = ($urandom_range(0, 99) != 0);
            tick($urandom_range(0, 99) < 85, w, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 10, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                if (errs < 10) $display("FAIL random cycle %0d instr %h: got %b, want %b", c, w, o, e);
                errs++;
            end
            commit();
        end
        rst = 1'b1;
    endtask

    initial begin
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        test_reset();
        test_fwd_ex();
        test_fwd_ma();
        test_load_use();
        test_r0();
        test_branch_freeze();
        test_rst_mid_ldstall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
